input_skew_buffer: RTL and testbench

INPUT_SKEW_BUFFER -- requirements
Module: input_skew_buffer

---
 rtl/input_skew_buffer_pkg.sv | 24 ++
 rtl/input_skew_buffer_skew_lane.sv | 40 ++++
 rtl/input_skew_buffer.sv | 93 +++++++++
 tb/tb_input_skew_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_skew_buffer_pkg.sv
// Shared types and Q8.8 helpers for the input skew buffer and its bench.
package input_skew_buffer_pkg;

  typedef logic signed [15:0] fixed16_t;

  localparam int FRAC_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Whole-number value to Q8.8 (e.g. -1 -> 0xFF00)
  function automatic fixed16_t int_to_fixed(input int value);
    return fixed16_t'(value <<< FRAC_BITS);
  endfunction

  // Q8.8 to whole-number value, truncating toward minus infinity
  function automatic int fixed_to_int(input fixed16_t value);
    return int'(value) >>> FRAC_BITS;
  endfunction

endpackage

// File: rtl/input_skew_buffer_skew_lane.sv
// One skew lane: an enabled shift register of DEPTH stages carrying data plus a valid flag.
module skew_lane
  import input_skew_buffer_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  // Shift every stage forward on an enabled cycle; hold everything otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= '0;
    end else if (en) begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/input_skew_buffer.sv
// Input skew buffer: feeds lane i of a systolic array through i+1 register stages so
// that consecutive input vectors enter the array as a diagonal wavefront.
module input_skew_buffer
  import input_skew_buffer_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_last,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_lane_valid,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;
  logic             advance;
  logic             accept;
  logic             tail_exit;

  // A low out_ready stalls every lane; new vectors are refused while the tail drains.
  // rst_n gates in_ready so it reads 0 for the whole reset interval.
  assign advance   = out_ready;
  assign in_ready  = rst_n && out_ready && (state != ST_DRAIN);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  assign tail_exit = (state == ST_DRAIN) && advance && (drain_cnt == '0)
                     && out_lane_valid[N-1];

  // Lane i gets depth i+1; a non-accepting advance injects a zero bubble
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] head_data;

    assign head_data = accept ? in_data[i*DATA_W +: DATA_W] : '0;

    skew_lane #(
      .DEPTH  (i + 1),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance),
      .in_data   (head_data),
      .in_valid  (accept),
      .out_data  (out_data[i*DATA_W +: DATA_W]),
      .out_valid (out_lane_valid[i])
    );
  end

  // Matrix framing: IDLE until the first vector, STREAM until in_last, DRAIN until the tail exits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (accept) state <= in_last ? ST_DRAIN : ST_STREAM;
        ST_STREAM: if (accept && in_last) state <= ST_DRAIN;
        ST_DRAIN:  if (tail_exit) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Counts the advances still needed for the last vector to reach the end of lane N-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (accept && in_last) begin
      drain_cnt <= CNT_W'(N - 1);
    end else if ((state == ST_DRAIN) && advance && (drain_cnt != '0)) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // done is a registered one-cycle pulse following the advance that retires the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= tail_exit;
    end
  end

endmodule

// File: tb/tb_input_skew_buffer.sv
// Scoreboard bench for input_skew_buffer (N=4, Q8.8 data).
`timescale 1ns/1ps
module tb_input_skew_buffer;
  import input_skew_buffer_pkg::*;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int BIG = 1 << 30;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] in_data = '0;
  logic           in_last = 1'b0;
  logic           out_ready = 1'b1;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_lane_valid;
  logic           busy;
  logic           done;

  int errors = 0;
  int checks = 0;
  int adv_count = 0;
  bit last_edge_adv = 1'b0;

  exp_t         lane_q [N][$];
  int           done_q [$];
  int           cur_start = BIG;
  int           cur_done = BIG;
  bit           in_matrix = 1'b0;
  logic [W-1:0] shown_data [N];
  logic [N-1:0] shown_valid = '0;

  always #5 clk = ~clk;

  input_skew_buffer #(.N(N), .DATA_W(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_lane_valid (out_lane_valid),
    .busy           (busy),
    .done           (done)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (t=%0t adv=%0d)",
               name, actual, expected, $time, adv_count);
    end
  endtask

  function automatic logic [N*W-1:0] pack4(input fixed16_t a, input fixed16_t b,
                                           input fixed16_t c, input fixed16_t d);
    return {d, c, b, a};
  endfunction

  function automatic logic [N*W-1:0] make_row(input int base);
    return pack4(int_to_fixed(base), int_to_fixed(base + 1),
                 int_to_fixed(base + 2), int_to_fixed(base + 3));
  endfunction

  // Count advancing edges; element of lane i accepted at count a is due at a+i+1
  always @(posedge clk) begin
    last_edge_adv = rst_n && out_ready;
    if (last_edge_adv) adv_count++;
  end

  // One cycle of stimulus; on an expected accept, push per-lane expectations
  task automatic applyStimulus(input bit v, input logic [N*W-1:0] d, input bit last,
                               input bit ordy, input bit exp_rdy);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_last   = last;
    out_ready = ordy;
    @(negedge clk);
    checkOutput("in_ready", in_ready, exp_rdy);
    if (v && exp_rdy) begin
      for (int i = 0; i < N; i++) begin
        e.data = d[i*W +: W];
        e.due  = adv_count + i + 1;
        lane_q[i].push_back(e);
      end
      if (!in_matrix) begin
        in_matrix = 1'b1;
        cur_start = adv_count;
        cur_done  = BIG;
      end
      if (last) begin
        in_matrix = 1'b0;
        cur_done  = adv_count + N + 1;
        done_q.push_back(adv_count + N + 1);
      end
    end
  endtask

  task automatic drainCycles(input int n, input bit v, input logic [N*W-1:0] d,
                             input bit last);
    for (int k = 0; k < n; k++) applyStimulus(v, d, last, 1'b1, 1'b0);
  endtask

  task automatic applyReset();
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      lane_q[i].delete();
      shown_data[i] = '0;
    end
    shown_valid = '0;
    done_q.delete();
    in_matrix = 1'b0;
    cur_start = BIG;
    cur_done  = BIG;
    #1;
    checkOutput("reset immediate out_data", out_data, '0);
    checkOutput("reset immediate lane_valid", out_lane_valid, '0);
    checkOutput("reset immediate busy", busy, 1'b0);
    checkOutput("reset immediate done", done, 1'b0);
    checkOutput("reset immediate in_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: pops expectations as elements present themselves, checks freeze on stalls
  always @(negedge clk) begin
    exp_t e;
    bit   done_exp;
    done_exp = 1'b0;
    if (!rst_n) begin
      checkOutput("reset out_data", out_data, '0);
      checkOutput("reset lane_valid", out_lane_valid, '0);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset done", done, 1'b0);
      checkOutput("reset in_ready", in_ready, 1'b0);
    end else begin
      if (last_edge_adv) begin
        for (int i = 0; i < N; i++) begin
          if (out_lane_valid[i]) begin
            if (lane_q[i].size() == 0) begin
              checkOutput($sformatf("lane%0d unexpected valid", i), 1, 0);
            end else begin
              e = lane_q[i].pop_front();
              checkOutput($sformatf("lane%0d data", i), out_data[i*W +: W], e.data);
              checkOutput($sformatf("lane%0d timing", i), adv_count, e.due);
              shown_data[i]  = e.data;
              shown_valid[i] = 1'b1;
            end
          end else begin
            checkOutput($sformatf("lane%0d bubble data", i), out_data[i*W +: W], '0);
            if (lane_q[i].size() != 0 && lane_q[i][0].due <= adv_count)
              checkOutput($sformatf("lane%0d missing element", i), 0, 1);
            shown_data[i]  = '0;
            shown_valid[i] = 1'b0;
          end
        end
        if (done_q.size() != 0 && done_q[0] == adv_count) begin
          done_exp = 1'b1;
          void'(done_q.pop_front());
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          checkOutput($sformatf("lane%0d held data", i), out_data[i*W +: W], shown_data[i]);
          checkOutput($sformatf("lane%0d held valid", i), out_lane_valid[i], shown_valid[i]);
        end
      end
      checkOutput("done", done, done_exp);
      checkOutput("busy", busy, (adv_count > cur_start) && (adv_count < cur_done));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) shown_data[i] = '0;
    applyReset();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Single vector with in_last: lane i valid i+1 advances later, done 5 after accept
    $display("[TB] scenario 1: single-vector matrix");
    applyStimulus(1'b1, make_row(1), 1'b1, 1'b1, 1'b1);
    drainCycles(N, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Back-to-back 4x4 matrix
    $display("[TB] scenario 2: 4x4 matrix back-to-back");
    applyStimulus(1'b1, make_row(1),  1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, make_row(5),  1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, make_row(9),  1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, make_row(13), 1'b1, 1'b1, 1'b1);
    drainCycles(N, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Three stalled cycles mid-stream: lanes frozen, in_ready low
    $display("[TB] scenario 3: stall mid-stream");
    applyStimulus(1'b1, make_row(17), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, make_row(21), 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, make_row(25), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, make_row(25), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, make_row(29), 1'b1, 1'b1, 1'b1);
    drainCycles(N, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Two upstream bubbles between rows 1 and 2
    $display("[TB] scenario 4: upstream bubbles");
    applyStimulus(1'b1, make_row(33), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, make_row(37), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, make_row(99), 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, make_row(99), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, make_row(41), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, make_row(45), 1'b1, 1'b1, 1'b1);
    drainCycles(N, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Reset during DRAIN, then a negative / extreme-value matrix
    $display("[TB] scenario 5: reset in drain");
    applyStimulus(1'b1, make_row(49), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, make_row(53), 1'b1, 1'b1, 1'b1);
    drainCycles(2, 1'b0, '0, 1'b0);
    applyReset();
    applyStimulus(1'b1, pack4(int_to_fixed(-1), int_to_fixed(-2),
                              int_to_fixed(-3), int_to_fixed(-128)), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, pack4(16'sh0080, 16'sh8000, 16'sh7FFF, 16'shFF80),
                  1'b1, 1'b1, 1'b1);
    drainCycles(N, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // in_valid held during DRAIN: refused until the state returns to IDLE
    $display("[TB] scenario 6: valid during drain");
    applyStimulus(1'b1, make_row(57), 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, make_row(61), 1'b1, 1'b1, 1'b1);
    drainCycles(N, 1'b1, make_row(65), 1'b1);
    applyStimulus(1'b1, make_row(65), 1'b1, 1'b1, 1'b1);
    drainCycles(N, 1'b0, '0, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < N; i++)
      checkOutput($sformatf("lane%0d leftover expectations", i), lane_q[i].size(), 0);
    checkOutput("leftover done expectations", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
